aes_uart_frame_sequencer: RTL and testbench

- Sequences the AES-128 core from a UART byte stream.
- Assembles a 32-byte frame (16 key bytes, then 16 plaintext bytes) from the UART receiver, pulses the core's start, and waits for completion.
- Streams the 16 ciphertext bytes back to the UART transmitter under a valid/ready handshake.
- Sits between the UART RX/TX byte interfaces and the AES core inside the top-level AES/UART wrapper.

---
 rtl/aes_uart_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_aes_uart_frame_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_uart_frame_sequencer.sv
// Frames UART bytes into an AES-128 key/plaintext pair, starts the core and streams the ciphertext back.
// Optional inter-byte idle timeout is compiled in with `define AES_SEQ_TIMEOUT_EN (adds rx_timeout).
module aes_uart_frame_sequencer #(
  parameter int unsigned BLOCK_BYTES = 16
`ifdef AES_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         aes_enable,
  output logic [127:0] aes_key,
  output logic [127:0] aes_block,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_result,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         frames_received,
  output logic         busy,
  output logic         rx_overrun
`ifdef AES_SEQ_TIMEOUT_EN
  , output logic       rx_timeout
`endif
);

  typedef enum logic [2:0] {RX_KEY, RX_BLK, START, WAIT, TX} state_t;

  localparam logic [3:0] LAST = 4'(BLOCK_BYTES - 1);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] res_q;
  logic         rx_phase, accept;
  logic         key_shift, blk_shift, res_load, res_shift, overrun_set;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int unsigned  TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q;
  logic          tmo_hit;

  // Idle counter only runs while a partial frame is pending.
  always_ff @(posedge clk) begin
    if (reset || accept || tmo_hit) begin
      tmo_q <= '0;
    end else if (rx_phase && cnt_q != '0) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  always_comb begin
    tmo_hit = rx_phase && (cnt_q != '0) && !accept && (tmo_q == TMO_LAST);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RX_KEY;
      cnt_q      <= '0;
      aes_key    <= '0;
      aes_block  <= '0;
      res_q      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (key_shift) aes_key <= {aes_key[119:0], rx_data};
      if (blk_shift) aes_block <= {aes_block[119:0], rx_data};
      // Ciphertext shifts left on each transfer so the next byte is always at the top.
      if (res_load) begin
        res_q <= aes_result;
      end else if (res_shift) begin
        res_q <= {res_q[119:0], 8'h00};
      end
      if (overrun_set) rx_overrun <= 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    key_shift       = 1'b0;
    blk_shift       = 1'b0;
    res_load        = 1'b0;
    res_shift       = 1'b0;
    overrun_set     = 1'b0;
    frames_received = 1'b0;
    aes_start       = 1'b0;
    tx_valid        = 1'b0;
    tx_data         = '0;
    rx_phase        = (state_q == RX_KEY) || (state_q == RX_BLK);
    accept          = rx_phase && rx_valid && aes_enable;
    busy            = !((state_q == RX_KEY) && (cnt_q == '0));
`ifdef AES_SEQ_TIMEOUT_EN
    rx_timeout      = 1'b0;
`endif

    case (state_q)
      RX_KEY: begin
        if (accept) begin
          key_shift = 1'b1;
          if (cnt_q == LAST) begin
            state_d = RX_BLK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_BLK: begin
        if (accept) begin
          blk_shift = 1'b1;
          if (cnt_q == LAST) begin
            frames_received = !reset;
            state_d         = START;
            cnt_d           = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: begin
        aes_start   = 1'b1;
        overrun_set = rx_valid;
        state_d     = WAIT;
      end
      WAIT: begin
        overrun_set = rx_valid;
        if (aes_done) begin
          res_load = 1'b1;
          state_d  = TX;
          cnt_d    = '0;
        end
      end
      TX: begin
        overrun_set = rx_valid;
        tx_valid    = 1'b1;
        tx_data     = res_q[127:120];
        if (tx_ready) begin
          res_shift = 1'b1;
          if (cnt_q == LAST) begin
            state_d = RX_KEY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = RX_KEY;
        cnt_d   = '0;
      end
    endcase

`ifdef AES_SEQ_TIMEOUT_EN
    if (tmo_hit && !reset) begin
      state_d    = RX_KEY;
      cnt_d      = '0;
      rx_timeout = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_aes_uart_frame_sequencer.sv
// Self-checking bench for aes_uart_frame_sequencer: randomized frames against a byte-queue reference model.
module tb_aes_uart_frame_sequencer;

  typedef logic [7:0] bq_t[$];
  typedef bit         bitq_t[$];
  typedef struct {
    int           fr_pos, fr_cnt, starts, early_tx, cycles, hold_bad;
    logic         start_now, txv_after, busy_after;
    logic [127:0] key, blk;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         aes_enable = 1'b1;
  logic [127:0] aes_key, aes_block;
  logic         aes_start;
  logic         aes_done = 1'b0;
  logic [127:0] aes_result = '0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         frames_received, busy, rx_overrun;
`ifdef AES_SEQ_TIMEOUT_EN
  logic         rx_timeout;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_uart_frame_sequencer #(
    .BLOCK_BYTES(16)
`ifdef AES_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .aes_enable(aes_enable),
    .aes_key(aes_key), .aes_block(aes_block), .aes_start(aes_start), .aes_done(aes_done),
    .aes_result(aes_result), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frames_received(frames_received), .busy(busy), .rx_overrun(rx_overrun)
`ifdef AES_SEQ_TIMEOUT_EN
    , .rx_timeout(rx_timeout)
`endif
  );

  // ---------------- reference model ----------------
  function automatic bq_t accepted_bytes(input bq_t d, input bitq_t en);
    bq_t q;
    for (int i = 0; i < d.size(); i++) if (en[i]) q.push_back(d[i]);
    return q;
  endfunction

  // Byte base of the block lands in the most significant byte.
  function automatic logic [127:0] pack(input bq_t q, input int base);
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = q[base+i];
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Random byte stream with enable gaps that yields exactly 32 accepted bytes.
  task automatic make_frame(input int gap_pct, output bq_t data, output bitq_t en);
    int acc = 0;
    data = {};
    en = {};
    while (acc < 32) begin
      bit e = ($urandom_range(0, 99) >= gap_pct);
      data.push_back(8'($urandom));
      en.push_back(e);
      if (e) acc++;
    end
  endtask

  // ---------------- stimulus drivers (observe only, never judge) ----------------
  task automatic send_seq(input bq_t data, input bitq_t en, output int fr_pos, output int fr_cnt);
    fr_pos = -1;
    fr_cnt = 0;
    for (int i = 0; i < data.size(); i++) begin
      rx_data = data[i];
      rx_valid = 1'b1;
      aes_enable = en[i];
      #1;
      if (frames_received) begin
        fr_cnt++;
        fr_pos = i;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    aes_enable = 1'b1;
    rx_data = '0;
  endtask

  task automatic core_reply(input logic [127:0] res, input bit poke, output int starts, output int early_tx);
    starts = 0;
    early_tx = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (aes_start) starts++;
      if (tx_valid) early_tx++;
      if (poke && c == 1) begin
        rx_valid = 1'b1;
        rx_data = 8'hA5;
      end
      @(negedge clk);
      rx_valid = 1'b0;
    end
    aes_done = 1'b1;
    aes_result = res;
    #1;
    if (tx_valid) early_tx++;
    @(negedge clk);
    aes_done = 1'b0;
    aes_result = rand128();
  endtask

  task automatic collect_tx(input bitq_t pat, input int n, output bq_t got, output int cycles, output int hold_bad);
    logic [7:0] last = '0;
    bit stalled = 1'b0;
    got = {};
    cycles = 0;
    hold_bad = 0;
    while (got.size() < n && cycles < 200) begin
      tx_ready = pat[cycles % pat.size()];
      #1;
      if (stalled && tx_valid && tx_data !== last) hold_bad++;
      stalled = tx_valid && !tx_ready;
      last = tx_data;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      cycles++;
      @(negedge clk);
    end
    tx_ready = 1'b0;
  endtask

  task automatic run_frame(input bq_t data, input bitq_t en, input logic [127:0] res, input bit poke,
                           input bitq_t rdy, output obs_t o, output bq_t got);
    int a, b;
    send_seq(data, en, a, b);
    o.fr_pos = a;
    o.fr_cnt = b;
    #1;
    o.start_now = aes_start;
    o.key = aes_key;
    o.blk = aes_block;
    core_reply(res, poke, a, b);
    o.starts = a;
    o.early_tx = b;
    collect_tx(rdy, 16, got, a, b);
    o.cycles = a;
    o.hold_bad = b;
    #1;
    o.txv_after = tx_valid;
    o.busy_after = busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'($urandom);
    aes_done = 1'b1;
    aes_result = rand128();
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    aes_done = 1'b0;
    tx_ready = 1'b0;
    #1;
    checks++; if (aes_key !== '0) begin failures++; $display("FAIL reset_key got=%h exp=0", aes_key); end
    checks++; if (aes_block !== '0) begin failures++; $display("FAIL reset_block got=%h exp=0", aes_block); end
    checks++; if (aes_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", aes_start); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (frames_received !== 1'b0) begin failures++; $display("FAIL reset_frames got=%b exp=0", frames_received); end
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", rx_overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips();
    bq_t data, got;
    bitq_t en;
    obs_t o;
    logic [127:0] ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int i = 0; i < 16; i++) data.push_back(8'(i));
    for (int i = 0; i < 16; i++) data.push_back(8'(i * 17));
    for (int i = 0; i < 32; i++) en.push_back(1'b1);
    run_frame(data, en, ct, 1'b0, '{1'b1}, o, got);
    checks++; if (o.fr_cnt !== 1 || o.fr_pos !== 31) begin failures++; $display("FAIL fips_frames cnt=%0d pos=%0d exp cnt=1 pos=31", o.fr_cnt, o.fr_pos); end
    checks++; if (o.start_now !== 1'b1) begin failures++; $display("FAIL fips_start_next got=%b exp=1", o.start_now); end
    checks++; if (o.starts !== 1) begin failures++; $display("FAIL fips_start_width got=%0d exp=1", o.starts); end
    checks++; if (o.key !== 128'h000102030405060708090a0b0c0d0e0f) begin failures++; $display("FAIL fips_key got=%h exp=000102030405060708090a0b0c0d0e0f", o.key); end
    checks++; if (o.blk !== 128'h00112233445566778899aabbccddeeff) begin failures++; $display("FAIL fips_block got=%h exp=00112233445566778899aabbccddeeff", o.blk); end
    checks++; if (o.early_tx !== 0) begin failures++; $display("FAIL fips_early_tx got=%0d exp=0", o.early_tx); end
    checks++; if (got.size() !== 16 || pack(got, 0) !== ct) begin failures++; $display("FAIL fips_tx_bytes n=%0d got=%h exp=%h", got.size(), pack(got, 0), ct); end
    checks++; if (o.cycles !== 16) begin failures++; $display("FAIL fips_tx_cycles got=%0d exp=16", o.cycles); end
    checks++; if (o.txv_after !== 1'b0 || o.busy_after !== 1'b0) begin failures++; $display("FAIL fips_tx_end tx_valid=%b busy=%b exp 0 0", o.txv_after, o.busy_after); end
  endtask

  task automatic test_backpressure();
    bq_t data, got, acc;
    bitq_t en;
    obs_t o;
    logic [127:0] res = rand128();
    make_frame(0, data, en);
    acc = accepted_bytes(data, en);
    run_frame(data, en, res, 1'b0, '{1'b1, 1'b0, 1'b0, 1'b1}, o, got);
    checks++; if (o.hold_bad !== 0) begin failures++; $display("FAIL bp_hold changes=%0d exp=0", o.hold_bad); end
    checks++; if (got.size() !== 16 || pack(got, 0) !== res) begin failures++; $display("FAIL bp_tx_bytes n=%0d got=%h exp=%h", got.size(), pack(got, 0), res); end
    checks++; if (o.cycles !== 32) begin failures++; $display("FAIL bp_cycles got=%0d exp=32", o.cycles); end
    checks++; if (o.key !== pack(acc, 0) || o.blk !== pack(acc, 16)) begin failures++; $display("FAIL bp_frame key=%h blk=%h exp %h %h", o.key, o.blk, pack(acc, 0), pack(acc, 16)); end
  endtask

  task automatic test_enable_gating();
    bq_t data, got, acc;
    bitq_t en;
    obs_t o;
    logic [127:0] res = rand128();
    for (int i = 0; i < 36; i++) begin
      data.push_back(8'($urandom));
      en.push_back(!(i >= 5 && i < 9));
    end
    acc = accepted_bytes(data, en);
    run_frame(data, en, res, 1'b0, '{1'b1}, o, got);
    checks++; if (o.fr_cnt !== 1 || o.fr_pos !== 35) begin failures++; $display("FAIL gate_frames cnt=%0d pos=%0d exp cnt=1 pos=35", o.fr_cnt, o.fr_pos); end
    checks++; if (o.key !== pack(acc, 0)) begin failures++; $display("FAIL gate_key got=%h exp=%h", o.key, pack(acc, 0)); end
    checks++; if (o.blk !== pack(acc, 16)) begin failures++; $display("FAIL gate_block got=%h exp=%h", o.blk, pack(acc, 16)); end
    checks++; if (o.start_now !== 1'b1 || o.starts !== 1) begin failures++; $display("FAIL gate_start now=%b count=%0d exp 1 1", o.start_now, o.starts); end
    checks++; if (got.size() !== 16 || pack(got, 0) !== res) begin failures++; $display("FAIL gate_tx_bytes n=%0d got=%h exp=%h", got.size(), pack(got, 0), res); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      bq_t data, got, acc;
      bitq_t en, rdy;
      obs_t o;
      logic [127:0] res = rand128();
      int ones = 0;
      make_frame(30, data, en);
      acc = accepted_bytes(data, en);
      for (int i = 0; i < $urandom_range(1, 5); i++) begin
        bit r = $urandom_range(0, 1) == 1;
        rdy.push_back(r);
        if (r) ones++;
      end
      if (ones == 0) rdy.push_back(1'b1);
      run_frame(data, en, res, 1'b0, rdy, o, got);
      checks++; if (o.fr_cnt !== 1 || o.fr_pos !== data.size() - 1) begin failures++; $display("FAIL rnd%0d_frames cnt=%0d pos=%0d exp pos=%0d", f, o.fr_cnt, o.fr_pos, data.size() - 1); end
      checks++; if (o.key !== pack(acc, 0) || o.blk !== pack(acc, 16)) begin failures++; $display("FAIL rnd%0d_frame key=%h blk=%h exp %h %h", f, o.key, o.blk, pack(acc, 0), pack(acc, 16)); end
      checks++; if (got.size() !== 16 || pack(got, 0) !== res || o.hold_bad !== 0) begin failures++; $display("FAIL rnd%0d_tx n=%0d got=%h exp=%h holdbad=%0d", f, got.size(), pack(got, 0), res, o.hold_bad); end
    end
  endtask

  task automatic test_overrun();
    bq_t data, got, acc;
    bitq_t en;
    obs_t o;
    logic [127:0] res = rand128();
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL ovr_initial got=%b exp=0", rx_overrun); end
    make_frame(0, data, en);
    run_frame(data, en, res, 1'b1, '{1'b1}, o, got);
    checks++; if (rx_overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", rx_overrun); end
    checks++; if (got.size() !== 16 || pack(got, 0) !== res) begin failures++; $display("FAIL ovr_tx_bytes n=%0d got=%h exp=%h", got.size(), pack(got, 0), res); end
    // stray completion strobe while idle must be ignored
    aes_done = 1'b1;
    aes_result = rand128();
    @(negedge clk);
    aes_done = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stray_done tx_valid=%b busy=%b exp 0 0", tx_valid, busy); end
    @(negedge clk);
    res = rand128();
    make_frame(20, data, en);
    acc = accepted_bytes(data, en);
    run_frame(data, en, res, 1'b0, '{1'b1}, o, got);
    checks++; if (o.key !== pack(acc, 0) || got.size() !== 16 || pack(got, 0) !== res) begin failures++; $display("FAIL ovr_next key=%h exp=%h tx=%h exp=%h", o.key, pack(acc, 0), pack(got, 0), res); end
    checks++; if (rx_overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", rx_overrun); end
  endtask

  task automatic test_reset_mid_tx();
    bq_t data, got, acc, exp;
    bitq_t en;
    obs_t o;
    logic [127:0] res = rand128();
    int a, b;
    make_frame(0, data, en);
    send_seq(data, en, a, b);
    core_reply(res, 1'b1, a, b);
    collect_tx('{1'b1}, 7, got, a, b);
    for (int i = 0; i < 7; i++) exp.push_back(res[127-8*i -: 8]);
    checks++; if (got !== exp) begin failures++; $display("FAIL rst_partial_tx n=%0d exp n=7", got.size()); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || rx_overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_tx tx_valid=%b busy=%b overrun=%b exp 0 0 0", tx_valid, busy, rx_overrun); end
    @(negedge clk);
    res = rand128();
    make_frame(10, data, en);
    acc = accepted_bytes(data, en);
    run_frame(data, en, res, 1'b0, '{1'b1}, o, got);
    checks++; if (o.key !== pack(acc, 0) || o.blk !== pack(acc, 16)) begin failures++; $display("FAIL rst_next_frame key=%h blk=%h exp %h %h", o.key, o.blk, pack(acc, 0), pack(acc, 16)); end
    checks++; if (got.size() !== 16 || pack(got, 0) !== res || o.cycles !== 16) begin failures++; $display("FAIL rst_next_tx n=%0d got=%h exp=%h cycles=%0d", got.size(), pack(got, 0), res, o.cycles); end
  endtask

`ifdef AES_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bq_t data, got, acc;
    bitq_t en;
    obs_t o;
    logic [127:0] res = rand128();
    int a, b, pulses = 0, at = -1;
    for (int i = 0; i < 10; i++) begin
      data.push_back(8'($urandom));
      en.push_back(1'b1);
    end
    send_seq(data, en, a, b);
    for (int k = 0; k < 60; k++) begin
      #1;
      if (rx_timeout) begin
        pulses++;
        at = k;
      end
      @(negedge clk);
    end
    checks++; if (pulses !== 1 || at < 40) begin failures++; $display("FAIL timeout_pulse count=%0d at=%0d exp count=1 at>=40", pulses, at); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle busy=%b exp=0", busy); end
    make_frame(0, data, en);
    acc = accepted_bytes(data, en);
    run_frame(data, en, res, 1'b0, '{1'b1}, o, got);
    checks++; if (o.key !== pack(acc, 0) || o.blk !== pack(acc, 16)) begin failures++; $display("FAIL timeout_frame key=%h blk=%h exp %h %h", o.key, o.blk, pack(acc, 0), pack(acc, 16)); end
    checks++; if (got.size() !== 16 || pack(got, 0) !== res) begin failures++; $display("FAIL timeout_tx n=%0d got=%h exp=%h", got.size(), pack(got, 0), res); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_fips();
    test_backpressure();
    test_enable_gating();
    test_random_frames();
    test_overrun();
    test_reset_mid_tx();
`ifdef AES_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
